store_queue_fwd: RTL
====================

// Module: store_queue_fwd
// PURPOSE
//  Parametrised N-wide store queue for the superscalar OoO core; successor to the fixed 2-way LSQ store side.
//  Captures dispatched stores, snoops CDB_N result buses for base/data operands, forwards to younger loads,
//  and drains ROB-retired stores in order to the D-cache via a valid/ready + ack handshake.
//  Flushes uncommitted entries on mispredict.
// PARAMETERS
//  SQ_DEPTH    8   entries, power of 2, >= 2*DISP_W
//  DISP_W      2   stores dispatched / retired per cycle
//  CDB_N       2   CDB broadcast ports snooped
//  TAG_W       6   PRF tag width ($clog2(`PRF_SIZE))
//  PTR_W       $clog2(SQ_DEPTH)+1   queue pointer incl. wrap bit (derived)
// PORTS
//  clock          in   1              rising-edge clock
//  reset          in   1              async, active-low; 0 = in reset
//  cdb_valid      in   CDB_N          per-port broadcast valid
//  cdb_tag        in   CDB_N*TAG_W    per-port PRF tag
//  cdb_data       in   CDB_N*64       per-port result
//  disp_valid     in   DISP_W         slot k carries a store (slots fill lowest-first)
//  disp_base      in   DISP_W*64      base value, or tag in [TAG_W-1:0] when !disp_base_rdy
//  disp_base_rdy  in   DISP_W         base is a value
//  disp_data      in   DISP_W*64      store data, or tag when !disp_data_rdy
//  disp_data_rdy  in   DISP_W         data is a value
//  disp_offset    in   DISP_W*16      signed displacement
//  disp_ready     out  1              free entries >= DISP_W
//  sq_tail        out  PTR_W          tail pointer; loads record it at dispatch as their age
//  ret_cnt        in   $clog2(DISP_W+1)  stores retired by ROB this cycle
//  flush          in   1              mispredict: drop all uncommitted entries
//  ld_valid       in   1              load forwarding lookup
//  ld_addr        in   64             load address (8-byte aligned)
//  ld_age         in   PTR_W          sq_tail captured at load dispatch
//  fwd_hit        out  1              youngest older matching store has data
//  fwd_data       out  64             forwarded data
//  fwd_stall      out  1              older store with unknown address, or matching one without data
//  mem_req_valid  out  1              store write request
//  mem_req_addr   out  64             store address
//  mem_req_data   out  64             store data
//  mem_req_ready  in   1              D-cache accepts request
//  mem_ack        in   1              write complete
// BEHAVIOUR
//  Reset: head/commit/tail = 0, all entries invalid, FSM IDLE. Outputs 0 except disp_ready = 1.
//  Pointers:
//   - Entries in [head, tail). [head, commit) are committed. Wrap bit distinguishes full from empty.
//  Dispatch:
//   - Accepted only when disp_ready=1. Each valid slot is written at tail+k; tail advances by popcount(disp_valid).
//  Operand capture:
//   - Any not-ready operand whose tag matches any cdb_valid port captures that cdb_data.
//   - The same-cycle dispatch entry also snoops. The lowest CDB port wins if duplicated.
//   - Address = base + sext(offset), registered one cycle after the base is ready. addr_rdy then set.
//  Retire:
//   - commit += ret_cnt. A committed entry always has addr_rdy and data_rdy (ROB guarantees this).
//  Flush:
//   - tail := commit after this cycle's retire is applied. Dispatch in the same cycle is dropped.
//   - Committed entries and drain are unaffected.
//  Forwarding (combinational):
//   - Scans entries in [head, ld_age), compared on addr[63:3].
//   - Youngest older store with unknown address -> fwd_stall=1, fwd_hit=0.
//   - Otherwise the youngest match decides: data_rdy -> fwd_hit=1 with fwd_data; else fwd_stall=1.
//   - No match -> fwd_hit=0, fwd_stall=0. All outputs 0 when !ld_valid.
//  Drain FSM:
//   - IDLE -> REQ when head != commit.
//   - REQ drives mem_req_valid with the head entry's addr/data; these are held stable until ready.
//   - REQ -> WAIT on mem_req_ready.
//   - WAIT -> IDLE on mem_ack; the head entry is popped (head+1) in the same cycle.
//   - Throughput: one store per 3 cycles minimum.
//  Boundaries:
//   - Full: disp_ready drops when free < DISP_W.
//   - Pop + dispatch in the same cycle: free count uses pre-pop occupancy.
//   - Pointer wrap at SQ_DEPTH toggles the wrap bit.
//   - Reset asserted mid-drain aborts the request at once; mem_req_valid goes to 0 asynchronously.
// TESTING
//  1. Store, base tag 4 / data ready 0xAB, offset 0x10; CDB port1 tag4 = 0x100.
//     -> Two cycles later a load with addr 0x110 gets fwd_hit=1, fwd_data=0xAB.
//  2. Two stores to 0x200 (data 1, then 2), then a load to 0x200 -> fwd_data=2.
//     Same load with ld_age between the two stores -> fwd_data=1.
//  3. Older store with unresolved base plus load to any address -> fwd_stall=1. CDB resolves the base -> stall clears.
//  4. Fill SQ_DEPTH entries -> disp_ready=0.
//     Retire 2, ready held low 3 cycles -> req held stable. Then ready, then ack -> one pop.
//  5. Three stores dispatched, ret_cnt=1, flush in the same cycle.
//     -> sq_tail = head+1; only that store drains; the next dispatch reuses slot +1.
//  6. Reset pulled low during WAIT -> all outputs 0, disp_ready=1, queue empty after release.

Source files
------------

// File: rtl/store_queue_fwd.sv
// Store queue with CDB operand snooping, store-to-load forwarding and an
// in-order drain to the D-cache.
//
// Ports:
//   clock, reset                     rising-edge clock, async active-low reset
//   cdb_valid/cdb_tag/cdb_data       CDB_N snooped result broadcasts
//   disp_valid/disp_base[_rdy]/      DISP_W store dispatch slots (lowest-first);
//   disp_data[_rdy]/disp_offset      not-ready operands carry a PRF tag
//   disp_ready                       room for a full dispatch group
//   sq_tail                          tail pointer, recorded by loads as their age
//   ret_cnt, flush                   ROB retire count, mispredict flush
//   ld_valid/ld_addr/ld_age          load forwarding lookup
//   fwd_hit/fwd_data/fwd_stall       forwarding result (combinational)
//   mem_req_valid/addr/data,
//   mem_req_ready, mem_ack           D-cache write request / completion
module store_queue_fwd #(
    parameter int unsigned SQ_DEPTH = 8,
    parameter int unsigned DISP_W   = 2,
    parameter int unsigned CDB_N    = 2,
    parameter int unsigned TAG_W    = 6,
    localparam int unsigned PTR_W   = $clog2(SQ_DEPTH) + 1,
    localparam int unsigned RET_W   = $clog2(DISP_W + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [CDB_N-1:0]       cdb_valid,
    input  logic [CDB_N*TAG_W-1:0] cdb_tag,
    input  logic [CDB_N*64-1:0]    cdb_data,
    input  logic [DISP_W-1:0]      disp_valid,
    input  logic [DISP_W*64-1:0]   disp_base,
    input  logic [DISP_W-1:0]      disp_base_rdy,
    input  logic [DISP_W*64-1:0]   disp_data,
    input  logic [DISP_W-1:0]      disp_data_rdy,
    input  logic [DISP_W*16-1:0]   disp_offset,
    output logic                   disp_ready,
    output logic [PTR_W-1:0]       sq_tail,
    input  logic [RET_W-1:0]       ret_cnt,
    input  logic                   flush,
    input  logic                   ld_valid,
    input  logic [63:0]            ld_addr,
    input  logic [PTR_W-1:0]       ld_age,
    output logic                   fwd_hit,
    output logic [63:0]            fwd_data,
    output logic                   fwd_stall,
    output logic                   mem_req_valid,
    output logic [63:0]            mem_req_addr,
    output logic [63:0]            mem_req_data,
    input  logic                   mem_req_ready,
    input  logic                   mem_ack
);

    localparam int unsigned IDX_W = $clog2(SQ_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} drain_e;

    // Queue pointers (with wrap bit) and entry storage
    logic [PTR_W-1:0]    head, commit, tail;
    logic [63:0]         e_base [SQ_DEPTH];
    logic [63:0]         e_data [SQ_DEPTH];
    logic [15:0]         e_off  [SQ_DEPTH];
    logic [63:0]         e_addr [SQ_DEPTH];
    logic [SQ_DEPTH-1:0] e_base_rdy, e_data_rdy, e_addr_rdy;

    drain_e state, state_nxt;

    logic [PTR_W-1:0] occ, free_cnt, disp_cnt, commit_nxt;
    logic             disp_fire, pop;

    logic [IDX_W-1:0] slot_idx  [DISP_W];
    logic [64:0]      snp_sbase [DISP_W];
    logic [64:0]      snp_sdata [DISP_W];
    logic [64:0]      snp_ebase [SQ_DEPTH];
    logic [64:0]      snp_edata [SQ_DEPTH];

    logic             any_unk, m_found, m_rdy;
    logic [63:0]      m_data;
    logic [PTR_W-1:0] scan_len, scan_ptr;
    logic [IDX_W-1:0] scan_idx, head_idx;

    // Low address bits are ignored by the doubleword compare
    logic unused_ld_lsb;
    assign unused_ld_lsb = ^ld_addr[2:0];

    // CDB lookup: returns {hit, data}; the lowest matching port wins
    function automatic logic [64:0] cdb_snoop(input logic [TAG_W-1:0] tag);
        logic [64:0] r;
        r = '0;
        for (int p = CDB_N - 1; p >= 0; p--) begin
            if (cdb_valid[p] && (cdb_tag[p*TAG_W +: TAG_W] == tag)) begin
                r = {1'b1, cdb_data[p*64 +: 64]};
            end
        end
        return r;
    endfunction

    // Occupancy, dispatch acceptance and pointer updates
    always_comb begin
        occ        = tail - head;
        free_cnt   = PTR_W'(SQ_DEPTH) - occ;
        disp_ready = (free_cnt >= PTR_W'(DISP_W));
        disp_fire  = disp_ready && !flush && (|disp_valid);
        commit_nxt = commit + PTR_W'(ret_cnt);
        pop        = (state == S_WAIT) && mem_ack;
        sq_tail    = tail;
        head_idx   = head[IDX_W-1:0];
    end

    // Per-slot dispatch target and same-cycle CDB snoop
    always_comb begin
        disp_cnt = '0;
        for (int k = 0; k < DISP_W; k++) begin
            slot_idx[k]  = IDX_W'(tail + disp_cnt);
            snp_sbase[k] = cdb_snoop(disp_base[k*64 +: TAG_W]);
            snp_sdata[k] = cdb_snoop(disp_data[k*64 +: TAG_W]);
            disp_cnt     = disp_cnt + PTR_W'(disp_valid[k]);
        end
    end

    // CDB snoop for resident entries
    always_comb begin
        for (int i = 0; i < SQ_DEPTH; i++) begin
            snp_ebase[i] = cdb_snoop(e_base[i][TAG_W-1:0]);
            snp_edata[i] = cdb_snoop(e_data[i][TAG_W-1:0]);
        end
    end

    // Pointer registers; flush rewinds tail to the post-retire commit point
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head   <= '0;
            commit <= '0;
            tail   <= '0;
        end else begin
            commit <= commit_nxt;
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            if (flush) begin
                tail <= commit_nxt;
            end else if (disp_fire) begin
                tail <= tail + disp_cnt;
            end
        end
    end

    // Entry storage: operand capture, address generation, dispatch writes
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SQ_DEPTH; i++) begin
                e_base[i] <= '0;
                e_data[i] <= '0;
                e_off[i]  <= '0;
                e_addr[i] <= '0;
            end
            e_base_rdy <= '0;
            e_data_rdy <= '0;
            e_addr_rdy <= '0;
        end else begin
            for (int i = 0; i < SQ_DEPTH; i++) begin
                if (!e_base_rdy[i] && snp_ebase[i][64]) begin
                    e_base[i]     <= snp_ebase[i][63:0];
                    e_base_rdy[i] <= 1'b1;
                end
                if (!e_data_rdy[i] && snp_edata[i][64]) begin
                    e_data[i]     <= snp_edata[i][63:0];
                    e_data_rdy[i] <= 1'b1;
                end
                // Address lags base readiness by one cycle
                if (e_base_rdy[i] && !e_addr_rdy[i]) begin
                    e_addr[i]     <= e_base[i] + {{48{e_off[i][15]}}, e_off[i]};
                    e_addr_rdy[i] <= 1'b1;
                end
            end
            // New entries overwrite whatever the stale slot was doing
            if (disp_fire) begin
                for (int k = 0; k < DISP_W; k++) begin
                    if (disp_valid[k]) begin
                        e_off[slot_idx[k]]      <= disp_offset[k*16 +: 16];
                        e_addr_rdy[slot_idx[k]] <= 1'b0;
                        if (disp_base_rdy[k] || !snp_sbase[k][64]) begin
                            e_base[slot_idx[k]] <= disp_base[k*64 +: 64];
                        end else begin
                            e_base[slot_idx[k]] <= snp_sbase[k][63:0];
                        end
                        e_base_rdy[slot_idx[k]] <= disp_base_rdy[k] || snp_sbase[k][64];
                        if (disp_data_rdy[k] || !snp_sdata[k][64]) begin
                            e_data[slot_idx[k]] <= disp_data[k*64 +: 64];
                        end else begin
                            e_data[slot_idx[k]] <= snp_sdata[k][63:0];
                        end
                        e_data_rdy[slot_idx[k]] <= disp_data_rdy[k] || snp_sdata[k][64];
                    end
                end
            end
        end
    end

    // Forwarding: scan older stores oldest-to-youngest so the youngest match wins
    always_comb begin
        fwd_hit   = 1'b0;
        fwd_data  = '0;
        fwd_stall = 1'b0;
        any_unk   = 1'b0;
        m_found   = 1'b0;
        m_rdy     = 1'b0;
        m_data    = '0;
        scan_len  = ld_age - head;
        scan_ptr  = head;
        scan_idx  = head_idx;
        for (int i = 0; i < SQ_DEPTH; i++) begin
            scan_ptr = head + PTR_W'(i);
            scan_idx = scan_ptr[IDX_W-1:0];
            if (PTR_W'(i) < scan_len) begin
                if (!e_addr_rdy[scan_idx]) begin
                    any_unk = 1'b1;
                end else if (e_addr[scan_idx][63:3] == ld_addr[63:3]) begin
                    m_found = 1'b1;
                    m_rdy   = e_data_rdy[scan_idx];
                    m_data  = e_data[scan_idx];
                end
            end
        end
        if (ld_valid) begin
            if (any_unk) begin
                fwd_stall = 1'b1;
            end else if (m_found) begin
                if (m_rdy) begin
                    fwd_hit  = 1'b1;
                    fwd_data = m_data;
                end else begin
                    fwd_stall = 1'b1;
                end
            end
        end
    end

    // Drain FSM: state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Drain FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (head != commit) state_nxt = S_REQ;
            S_REQ:   if (mem_req_ready)  state_nxt = S_WAIT;
            S_WAIT:  if (mem_ack)        state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Drain FSM: outputs; committed head entry is immutable, so the request is stable
    always_comb begin
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        mem_req_data  = '0;
        if (state == S_REQ) begin
            mem_req_valid = 1'b1;
            mem_req_addr  = e_addr[head_idx];
            mem_req_data  = e_data[head_idx];
        end
    end

endmodule
